// File: rtl/node_packet_queue.sv
// -----------------------------------------------------------------------------
// node_packet_queue
//
// Node-side staging block between a processing node and the router core.
//
// Outbound path: node packets are buffered in a DEPTH-entry FIFO. The head
// entry is presented to the core on Packet_From_Node / Packet_From_Node_Valid.
// It is popped when the core pulses Core_Load_Ack. Between consecutive packets
// the valid line drops for exactly one cycle.
//
// Inbound path: a rising edge on Packet_To_Node_Valid latches Packet_To_Node
// into a holding register. The node drains it with Node_Rx_Valid / Node_Rx_Ack.
//
// Optional feature macro: QUEUE_STATS_EN
//   Adds Sent_Count (pops) and Drop_Count (refused pushes plus inbound
//   overruns, saturating at 255).
//
// Ports:
//   Clk_R                  in   system clock, rising edge
//   Rst                    in   synchronous reset, active-high
//   Node_Wr_En             in   node pushes Node_Wr_Data this cycle
//   Node_Wr_Data           in   outbound packet from node       [OUT_W]
//   Queue_Full             out  count == DEPTH
//   Queue_Count            out  entries held                    [clog2(DEPTH)+1]
//   Overflow               out  one-cycle pulse: push refused
//   Packet_From_Node       out  head entry to core               [OUT_W]
//   Packet_From_Node_Valid out  head presented to core
//   Core_Load_Ack          in   core latched the presented packet
//   Packet_To_Node         in   inbound packet from core         [IN_W]
//   Packet_To_Node_Valid   in   inbound valid level from core
//   Node_Rx_Data           out  captured inbound packet          [IN_W]
//   Node_Rx_Valid          out  Node_Rx_Data unread
//   Node_Rx_Ack            in   node consumed Node_Rx_Data
//   Rx_Overrun             out  one-cycle pulse: unread packet overwritten
//   Sent_Count             out  (QUEUE_STATS_EN) pops since reset [16]
//   Drop_Count             out  (QUEUE_STATS_EN) drops, saturating [8]
// -----------------------------------------------------------------------------
module node_packet_queue #(
    parameter int DEPTH = 4,
    parameter int OUT_W = 29,
    parameter int IN_W  = 24
) (
    input  logic                       Clk_R,
    input  logic                       Rst,
    input  logic                       Node_Wr_En,
    input  logic [OUT_W-1:0]           Node_Wr_Data,
    output logic                       Queue_Full,
    output logic [$clog2(DEPTH):0]     Queue_Count,
    output logic                       Overflow,
    output logic [OUT_W-1:0]           Packet_From_Node,
    output logic                       Packet_From_Node_Valid,
    input  logic                       Core_Load_Ack,
    input  logic [IN_W-1:0]            Packet_To_Node,
    input  logic                       Packet_To_Node_Valid,
    output logic [IN_W-1:0]            Node_Rx_Data,
    output logic                       Node_Rx_Valid,
    input  logic                       Node_Rx_Ack,
    output logic                       Rx_Overrun
`ifdef QUEUE_STATS_EN
    ,
    output logic [15:0]                Sent_Count,
    output logic [7:0]                 Drop_Count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Outbound FIFO
    // -------------------------------------------------------------------------
    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    state_t state_q;
    state_t state_d;

    logic push;
    logic pop;
    logic overflow_evt;

    // Full comes from the registered count, so a same-cycle pop never makes
    // room for a push.
    assign Queue_Full   = (count == CNT_W'(DEPTH));
    assign Queue_Count  = count;
    assign push         = Node_Wr_En && !Queue_Full;
    assign overflow_evt = Node_Wr_En && Queue_Full;
    // Only a presented packet can be acknowledged; acks in EMPTY/GAP are ignored.
    assign pop          = (state_q == ST_PRESENT) && Core_Load_Ack;

    // NOTE: the storage array is cleared on reset here because the packet
    // output must read back as zero; plain RAM macros would normally be left
    // unreset.
    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr] <= Node_Wr_Data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            Overflow <= 1'b0;
        end else begin
            Overflow <= overflow_evt;
        end
    end

    // -------------------------------------------------------------------------
    // Output FSM: state register / next state / outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: combinational blocks use blocking assignments and give every
    // target a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:   if (count != '0) state_d = ST_PRESENT;
            ST_PRESENT: if (Core_Load_Ack) state_d = ST_GAP;
            // In GAP the count already reflects the pop that got us here.
            ST_GAP:     state_d = (count != '0) ? ST_PRESENT : ST_EMPTY;
            default:    state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        Packet_From_Node_Valid = 1'b0;
        if (state_q == ST_PRESENT) begin
            Packet_From_Node_Valid = 1'b1;
        end
    end

    // The head is captured on entry to PRESENT and held, so the core sees a
    // stable word even if the node pushes during the presentation.
    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            Packet_From_Node <= '0;
        end else if (state_d == ST_PRESENT && state_q != ST_PRESENT) begin
            Packet_From_Node <= mem[rd_ptr];
        end
    end

    // -------------------------------------------------------------------------
    // Inbound capture
    // -------------------------------------------------------------------------
    logic rx_valid_prev;
    logic rx_rise;
    logic overrun_evt;

    assign rx_rise     = Packet_To_Node_Valid && !rx_valid_prev;
    // A capture that coincides with the node's ack replaces consumed data,
    // so it is not an overrun.
    assign overrun_evt = rx_rise && Node_Rx_Valid && !Node_Rx_Ack;

    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            rx_valid_prev <= 1'b0;
            Node_Rx_Data  <= '0;
            Node_Rx_Valid <= 1'b0;
            Rx_Overrun    <= 1'b0;
        end else begin
            rx_valid_prev <= Packet_To_Node_Valid;
            Rx_Overrun    <= overrun_evt;
            if (rx_rise) begin
                Node_Rx_Data  <= Packet_To_Node;
                Node_Rx_Valid <= 1'b1;
            end else if (Node_Rx_Ack) begin
                Node_Rx_Valid <= 1'b0;
            end
        end
    end

`ifdef QUEUE_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
    logic [8:0] drop_sum;

    // Both drop sources can fire in one cycle; each one counts.
    assign drop_sum = {1'b0, Drop_Count} + 9'(overflow_evt) + 9'(overrun_evt);

    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            Sent_Count <= '0;
            Drop_Count <= '0;
        end else begin
            if (pop) begin
                Sent_Count <= Sent_Count + 16'd1;
            end
            Drop_Count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end
`endif

endmodule
